lm_display_arbiter: RTL and testbench

- Shares the 8 board LEDs between four message sources, each a single-cycle valid strobe with a payload:
  - UART receive data
  - UART error code
  - CM (VGA) error code
  - configuration notification
- Holds a one-deep pending buffer per source and grants the LEDs to one source at a time for a fixed hold time, with a blank gap between messages.
- Sits between the UART/CM/config producers and the LED pins, replacing the static LED assignment in the LED manager.

---
 rtl/lm_pkg.sv | 19 +
 rtl/lm_src_slot.sv | 39 +++
 rtl/lm_display_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_lm_display_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lm_pkg.sv
// Shared constants for the LED display arbiter: source ids, LED tags, FSM states.
package lm_pkg;

    localparam logic [1:0] SRC_DATA  = 2'd0;
    localparam logic [1:0] SRC_UERR  = 2'd1;
    localparam logic [1:0] SRC_CMERR = 2'd2;
    localparam logic [1:0] SRC_CFG   = 2'd3;

    localparam logic [1:0] TAG_UERR  = 2'b10;
    localparam logic [1:0] TAG_CMERR = 2'b01;
    localparam logic [1:0] TAG_CFG   = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        GAP
    } state_t;

endpackage

// File: rtl/lm_src_slot.sv
// One-deep pending buffer for a single message source with sticky overwrite flag.
module lm_src_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_clear,
    output logic             o_full,
    output logic [WIDTH-1:0] o_payload,
    output logic             o_ovf
);

    logic             r_full;
    logic [WIDTH-1:0] r_payload;
    logic             r_ovf;

    // A strobe on the grant edge refills the slot without counting as overwrite.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full    <= 1'b0;
            r_payload <= '0;
            r_ovf     <= 1'b0;
        end else if (i_valid) begin
            r_payload <= i_data;
            r_full    <= 1'b1;
            if (r_full && !i_clear)
                r_ovf <= 1'b1;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end
    end

    assign o_full    = r_full;
    assign o_payload = r_payload;
    assign o_ovf     = r_ovf;

endmodule

// File: rtl/lm_display_arbiter.sv
// Time-shares the board LEDs between four message sources with hold and gap timing.
// Define LM_ROUND_ROBIN_EN for rotating priority instead of fixed priority.
module lm_display_arbiter
    import lm_pkg::*;
#(
    parameter int WIDTH_LEDS          = 8,
    parameter int WIDTH_UART_DATA     = 8,
    parameter int WIDTH_UART_ERROR    = 3,
    parameter int WIDTH_VGA_ERROR     = 3,
    parameter int WIDTH_CONFIGURATION = 4,
    parameter int HOLD_CYCLES         = 50000000,
    parameter int GAP_CYCLES          = 5000000,
    parameter logic [WIDTH_LEDS-1:0] IDLE_PATTERN = 8'b01010101
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           UART_data_debug_switch,
    input  logic [WIDTH_UART_DATA-1:0]     UART_data,
    input  logic                           UART_data_valid,
    input  logic [WIDTH_UART_ERROR-1:0]    UART_errors,
    input  logic                           UART_errors_valid,
    input  logic [WIDTH_VGA_ERROR-1:0]     CM_errors,
    input  logic                           CM_errors_valid,
    input  logic [WIDTH_CONFIGURATION-1:0] config_notification,
    input  logic                           config_valid,
    output logic [WIDTH_LEDS-1:0]          leds,
    output logic [1:0]                     src_id,
    output logic                           busy,
    output logic [3:0]                     ovf_flags
);

    localparam int CMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t                  r_state, w_nstate;
    logic [WIDTH_LEDS-1:0]   r_leds, w_nleds, w_fmt;
    logic [1:0]              r_src, w_nsrc, w_sel;
    logic [CW-1:0]           r_hold, w_nhold, r_gap, w_ngap;
    logic [3:0]              w_full, w_ovf, w_elig, w_clear;
    logic                    w_grant, w_arb;

    logic [WIDTH_UART_DATA-1:0]     w_pl_data;
    logic [WIDTH_UART_ERROR-1:0]    w_pl_uerr;
    logic [WIDTH_VGA_ERROR-1:0]     w_pl_cmerr;
    logic [WIDTH_CONFIGURATION-1:0] w_pl_cfg;

    lm_src_slot #(.WIDTH(WIDTH_UART_DATA)) u_slot_data (
        .clk(clk), .rst(rst), .i_valid(UART_data_valid), .i_data(UART_data),
        .i_clear(w_clear[SRC_DATA]), .o_full(w_full[SRC_DATA]),
        .o_payload(w_pl_data), .o_ovf(w_ovf[SRC_DATA]));

    lm_src_slot #(.WIDTH(WIDTH_UART_ERROR)) u_slot_uerr (
        .clk(clk), .rst(rst), .i_valid(UART_errors_valid), .i_data(UART_errors),
        .i_clear(w_clear[SRC_UERR]), .o_full(w_full[SRC_UERR]),
        .o_payload(w_pl_uerr), .o_ovf(w_ovf[SRC_UERR]));

    lm_src_slot #(.WIDTH(WIDTH_VGA_ERROR)) u_slot_cmerr (
        .clk(clk), .rst(rst), .i_valid(CM_errors_valid), .i_data(CM_errors),
        .i_clear(w_clear[SRC_CMERR]), .o_full(w_full[SRC_CMERR]),
        .o_payload(w_pl_cmerr), .o_ovf(w_ovf[SRC_CMERR]));

    lm_src_slot #(.WIDTH(WIDTH_CONFIGURATION)) u_slot_cfg (
        .clk(clk), .rst(rst), .i_valid(config_valid), .i_data(config_notification),
        .i_clear(w_clear[SRC_CFG]), .o_full(w_full[SRC_CFG]),
        .o_payload(w_pl_cfg), .o_ovf(w_ovf[SRC_CFG]));

`ifdef LM_ROUND_ROBIN_EN
    logic [1:0] r_last;

    always_ff @(posedge clk) begin
        if (rst)
            r_last <= SRC_CFG;
        else if (w_grant)
            r_last <= w_sel;
    end
`endif

    // Debug switch masks everything but UART data; masked slots keep their data.
    always_comb begin
        w_elig = UART_data_debug_switch ? {3'b000, w_full[SRC_DATA]} : w_full;
        w_sel  = SRC_DATA;
`ifdef LM_ROUND_ROBIN_EN
        for (int k = 3; k >= 0; k--) begin
            logic [1:0] v_idx;
            v_idx = r_last + 2'(k) + 2'd1;
            if (w_elig[v_idx])
                w_sel = v_idx;
        end
`else
        if (w_elig[SRC_CMERR])
            w_sel = SRC_CMERR;
        else if (w_elig[SRC_UERR])
            w_sel = SRC_UERR;
        else if (w_elig[SRC_CFG])
            w_sel = SRC_CFG;
`endif
    end

    always_comb begin
        w_fmt = WIDTH_LEDS'(w_pl_data);
        unique case (w_sel)
            SRC_UERR:  w_fmt = {TAG_UERR,
                                {(WIDTH_LEDS-2-WIDTH_UART_ERROR){1'b0}}, w_pl_uerr};
            SRC_CMERR: w_fmt = {TAG_CMERR,
                                {(WIDTH_LEDS-2-WIDTH_VGA_ERROR){1'b0}}, w_pl_cmerr};
            SRC_CFG:   w_fmt = {TAG_CFG,
                                {(WIDTH_LEDS-2-WIDTH_CONFIGURATION){1'b0}}, w_pl_cfg};
            default:   w_fmt = WIDTH_LEDS'(w_pl_data);
        endcase
    end

    always_comb begin
        w_nstate = r_state;
        w_nleds  = r_leds;
        w_nsrc   = r_src;
        w_nhold  = r_hold;
        w_ngap   = r_gap;
        w_grant  = 1'b0;
        w_arb    = 1'b0;
        unique case (r_state)
            IDLE: w_arb = 1'b1;
            SHOW: begin
                if (r_hold != '0) begin
                    w_nhold = r_hold - CW'(1);
                end else if (GAP_CYCLES > 0) begin
                    w_nstate = GAP;
                    w_nleds  = '0;
                    w_ngap   = GAP_LD;
                end else begin
                    w_arb = 1'b1;
                end
            end
            GAP: begin
                if (r_gap != '0)
                    w_ngap = r_gap - CW'(1);
                else
                    w_arb = 1'b1;
            end
            default: w_nstate = IDLE;
        endcase
        // Shared by IDLE and every end-of-gap re-arbitration point.
        if (w_arb) begin
            if (|w_elig) begin
                w_grant  = 1'b1;
                w_nstate = SHOW;
                w_nleds  = w_fmt;
                w_nsrc   = w_sel;
                w_nhold  = HOLD_LD;
            end else begin
                w_nstate = IDLE;
                w_nleds  = IDLE_PATTERN;
            end
        end
    end

    assign w_clear = w_grant ? (4'b0001 << w_sel) : 4'b0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_leds  <= IDLE_PATTERN;
            r_src   <= SRC_DATA;
            r_hold  <= '0;
            r_gap   <= '0;
        end else begin
            r_state <= w_nstate;
            r_leds  <= w_nleds;
            r_src   <= w_nsrc;
            r_hold  <= w_nhold;
            r_gap   <= w_ngap;
        end
    end

    assign leds      = r_leds;
    assign src_id    = r_src;
    assign busy      = (r_state != IDLE);
    assign ovf_flags = w_ovf;

endmodule

// File: tb/tb_lm_display_arbiter.sv
// Self-checking bench for lm_display_arbiter with HOLD_CYCLES=4, GAP_CYCLES=2.
module tb_lm_display_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sw = 1'b0;
    logic [7:0] d = '0;
    logic       dv = 1'b0;
    logic [2:0] ue = '0;
    logic       uev = 1'b0;
    logic [2:0] ce = '0;
    logic       cev = 1'b0;
    logic [3:0] cf = '0;
    logic       cfv = 1'b0;
    logic [7:0] leds;
    logic [1:0] src_id;
    logic       busy;
    logic [3:0] ovf_flags;

    always #5 clk = ~clk;

    lm_display_arbiter #(
        .HOLD_CYCLES(4),
        .GAP_CYCLES(2)
    ) dut (
        .clk(clk), .rst(rst),
        .UART_data_debug_switch(sw),
        .UART_data(d), .UART_data_valid(dv),
        .UART_errors(ue), .UART_errors_valid(uev),
        .CM_errors(ce), .CM_errors_valid(cev),
        .config_notification(cf), .config_valid(cfv),
        .leds(leds), .src_id(src_id), .busy(busy), .ovf_flags(ovf_flags)
    );

    typedef struct {
        logic [7:0] v;
        logic [1:0] s;
    } exp_t;

    typedef struct {
        logic [3:0] m;
        logic [7:0] d;
        logic [2:0] ue;
        logic [2:0] ce;
        logic [3:0] cf;
    } vec_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   m_last = 3;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [7:0] fmt(input int s, input logic [7:0] dd,
                                       input logic [2:0] u, input logic [2:0] c,
                                       input logic [3:0] g);
        case (s)
            0: return dd;
            1: return 8'h80 | {5'd0, u};
            2: return 8'h40 | {5'd0, c};
            default: return 8'hC0 | {4'd0, g};
        endcase
    endfunction

    task automatic push_one(input int s, input logic [7:0] v);
        q.push_back('{v, 2'(s)});
        m_last = s;
    endtask

    // Expected display order for a batch arriving together while idle.
    task automatic push_batch(input logic [3:0] m, input logic [7:0] dd,
                              input logic [2:0] u, input logic [2:0] c,
                              input logic [3:0] g);
        int ord[4];
        int st;
        int s;
`ifdef LM_ROUND_ROBIN_EN
        st = m_last + 1;
        for (int k = 0; k < 4; k++) ord[k] = (st + k) % 4;
`else
        st = 0;
        ord = '{2, 1, 3, 0};
`endif
        for (int k = 0; k < 4; k++) begin
            s = ord[k];
            if (m[s]) push_one(s, fmt(s, dd, u, c, g));
        end
    endtask

    task automatic strobe(input logic [3:0] m, input logic [7:0] dd,
                          input logic [2:0] u, input logic [2:0] c,
                          input logic [3:0] g);
        @(negedge clk);
        d = dd; ue = u; ce = c; cf = g;
        dv = m[0]; uev = m[1]; cev = m[2]; cfv = m[3];
        @(negedge clk);
        dv = 1'b0; uev = 1'b0; cev = 1'b0; cfv = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        repeat (3) @(negedge clk);
        while ((busy || q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_timeout"}, 32'(n < 200), 32'd1);
        @(negedge clk);
        chk({nm, "_idle_leds"}, 32'(leds), 32'h55);
    endtask

    // Run monitor: each uninterrupted run of a busy, non-zero LED value is one message.
    logic [7:0] r_val;
    logic       r_busy;
    logic [1:0] r_src;
    int         r_len = 0;

    task automatic close_run();
        exp_t e;
        if (r_busy && r_val != 8'h00) begin
            if (q.size() == 0) begin
                n_chk++;
                $display("FAIL sb_unexpected: got %0h expected none", r_val);
            end else begin
                e = q.pop_front();
                chk("sb_leds", 32'(r_val), 32'(e.v));
                chk("sb_src", 32'(r_src), 32'(e.s));
                chk("sb_hold_len", 32'(r_len), 32'd4);
            end
        end else if (r_busy) begin
            chk("sb_gap_len", 32'(r_len), 32'd2);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            r_len = 0;
        end else begin
            if (r_len != 0 && (leds !== r_val || busy !== r_busy)) begin
                close_run();
                r_len = 0;
            end
            if (r_len == 0) begin
                r_val = leds; r_busy = busy; r_src = src_id; r_len = 1;
            end else begin
                r_len++;
            end
        end
    end

    vec_t tv[4];

    initial begin
        tv[0] = '{4'b0001, 8'hA5, 3'd0, 3'd0, 4'h0};
        tv[1] = '{4'b1111, 8'h11, 3'd5, 3'd2, 4'h9};
        tv[2] = '{4'b1010, 8'h00, 3'd7, 3'd0, 4'h0};
        tv[3] = '{4'b0101, 8'hFF, 3'd0, 3'd0, 4'h0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_leds", 32'(leds), 32'h55);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(ovf_flags), 32'd0);
        chk("rst_src", 32'(src_id), 32'd0);

        // Strobe-to-LED latency: capture edge, then grant edge.
        push_batch(4'b0001, 8'hA5, 3'd0, 3'd0, 4'h0);
        @(negedge clk);
        d = 8'hA5; dv = 1'b1;
        @(negedge clk);
        dv = 1'b0;
        chk("lat_edge1", 32'(leds), 32'h55);
        @(negedge clk);
        chk("lat_edge2", 32'(leds), 32'hA5);
        chk("lat_busy", 32'(busy), 32'd1);
        wait_idle("lat");

        foreach (tv[i]) begin
            push_batch(tv[i].m, tv[i].d, tv[i].ue, tv[i].ce, tv[i].cf);
            strobe(tv[i].m, tv[i].d, tv[i].ue, tv[i].ce, tv[i].cf);
            wait_idle($sformatf("vec%0d", i));
        end

        // Strobe on the grant edge: old value shown, new value kept, no overwrite.
        push_one(0, 8'h21);
        push_one(0, 8'h22);
        @(negedge clk);
        d = 8'h21; dv = 1'b1;
        @(negedge clk);
        d = 8'h22;
        @(negedge clk);
        dv = 1'b0;
        wait_idle("same_edge");
        chk("same_edge_ovf", 32'(ovf_flags), 32'd0);

        // Two CM errors while a data message is showing: newest wins, flag sticks.
        push_one(0, 8'h3C);
        strobe(4'b0001, 8'h3C, 3'd0, 3'd0, 4'h0);
        @(negedge clk);
        strobe(4'b0100, 8'h00, 3'd0, 3'd1, 4'h0);
        strobe(4'b0100, 8'h00, 3'd0, 3'd6, 4'h0);
        push_one(2, 8'h46);
        wait_idle("ovf");
        chk("ovf_flags", 32'(ovf_flags), 32'b0100);

        // Debug switch holds back the UART error until released.
        sw = 1'b1;
        strobe(4'b0010, 8'h00, 3'd3, 3'd0, 4'h0);
        repeat (5) @(negedge clk);
        chk("sw_blocked_busy", 32'(busy), 32'd0);
        chk("sw_blocked_leds", 32'(leds), 32'h55);
        push_one(0, 8'h7E);
        strobe(4'b0001, 8'h7E, 3'd0, 3'd0, 4'h0);
        wait_idle("sw_data");
        sw = 1'b0;
        push_one(1, 8'h83);
        wait_idle("sw_release");

        // Reset in the middle of SHOW with another message still pending.
        strobe(4'b1001, 8'h5A, 3'd0, 3'd0, 4'h2);
        repeat (3) @(negedge clk);
        chk("rst_mid_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_leds", 32'(leds), 32'h55);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_ovf", 32'(ovf_flags), 32'd0);
        chk("rst_mid_src", 32'(src_id), 32'd0);
        rst = 1'b0;
        m_last = 3;
        repeat (12) @(negedge clk);
        chk("rst_empty_busy", 32'(busy), 32'd0);
        chk("rst_empty_leds", 32'(leds), 32'h55);
        chk("sb_drained", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
